// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the fifo_stream_bh show-ahead FIFO slice.
// Sizing, default thresholds and threshold range checking live here.
package fifo_stream_pkg;

  localparam int DEF_DATA_WIDTH = 986;
  localparam int DEF_DEPTH_LG2  = 1;
  localparam int DEF_AE_THRESH  = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int level_width(input int depth_lg2);
    return depth_lg2 + 1;
  endfunction

  function automatic int def_af_thresh(input int depth_lg2);
    return (1 << depth_lg2) - 1;
  endfunction

  function automatic bit thresholds_ok(input int depth_lg2, input int af, input int ae);
    int depth;
    depth = 1 << depth_lg2;
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_stream_bh_if.sv
// Stream/status bundle between a producer-consumer pair and fifo_stream_bh.
// The master drives requests and data; the slave (the FIFO) drives head data and status.
interface fifo_stream_bh_if
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH_LG2  = DEF_DEPTH_LG2
);

  logic                       wren_i;
  logic                       rden_i;
  logic [FIFO_DATA_WIDTH-1:0] wdata_i;
  logic                       err_clr_i;
  logic [FIFO_DATA_WIDTH-1:0] rdata_o;
  logic                       full_o;
  logic                       empty_o;
  logic                       almost_full_o;
  logic                       almost_empty_o;
  logic [FIFO_DEPTH_LG2:0]    level_o;
  logic                       overflow_o;
  logic                       underflow_o;

  modport master (
    output wren_i, rden_i, wdata_i, err_clr_i,
    input  rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
           level_o, overflow_o, underflow_o
  );

  modport slave (
    input  wren_i, rden_i, wdata_i, err_clr_i,
    output rdata_o, full_o, empty_o, almost_full_o, almost_empty_o,
           level_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_stream_ctrl.sv
// Pointer, occupancy, acceptance and status control for fifo_stream_bh.
// Sticky overflow/underflow flags exist only when FIFO_STREAM_ERR_FLAGS_EN is defined.
module fifo_stream_ctrl
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_DEPTH_LG2 = DEF_DEPTH_LG2,
  parameter int AF_THRESH      = def_af_thresh(FIFO_DEPTH_LG2),
  parameter int AE_THRESH      = DEF_AE_THRESH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wren,
  input  logic                      rden,
  input  logic                      err_clr,
  output logic                      wr_acc,
  output logic [FIFO_DEPTH_LG2-1:0] wr_idx,
  output logic [FIFO_DEPTH_LG2-1:0] rd_idx,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [FIFO_DEPTH_LG2:0]   level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int LW    = level_width(FIFO_DEPTH_LG2);
  localparam int DEPTH = 1 << FIFO_DEPTH_LG2;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  if (!thresholds_ok(FIFO_DEPTH_LG2, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("fifo_stream_ctrl: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end

  logic [LW-1:0] wrptr_reg;
  logic [LW-1:0] rdptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          rd_acc;

  // A write at full only fits if the same edge frees the head slot.
  assign rd_acc = rden & ~empty;
  assign wr_acc = wren & (~full | rd_acc);

  always_comb begin
    level_next = level_reg;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrptr_reg <= '0;
      rdptr_reg <= '0;
      level_reg <= '0;
    end else begin
      if (wr_acc) wrptr_reg <= wrptr_reg + LW'(1);
      if (rd_acc) rdptr_reg <= rdptr_reg + LW'(1);
      level_reg <= level_next;
    end
  end

  assign wr_idx       = wrptr_reg[FIFO_DEPTH_LG2-1:0];
  assign rd_idx       = rdptr_reg[FIFO_DEPTH_LG2-1:0];
  assign level        = level_reg;
  assign full         = (level_reg == DEPTH_L);
  assign empty        = (level_reg == '0);
  assign almost_full  = (level_reg >= AF_L);
  assign almost_empty = (level_reg <= AE_L);

`ifdef FIFO_STREAM_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // A fresh event outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wren & ~wr_acc)  overflow_reg <= 1'b1;
      else if (err_clr)    overflow_reg <= 1'b0;
      if (rden & ~rd_acc)  underflow_reg <= 1'b1;
      else if (err_clr)    underflow_reg <= 1'b0;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: rtl/fifo_stream_bh.sv
// Show-ahead FIFO top: entry storage and head read mux around fifo_stream_ctrl.
// Optional sticky error flags are built when FIFO_STREAM_ERR_FLAGS_EN is defined.
module fifo_stream_bh
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH_LG2  = DEF_DEPTH_LG2,
  parameter int AF_THRESH       = def_af_thresh(FIFO_DEPTH_LG2),
  parameter int AE_THRESH       = DEF_AE_THRESH
) (
  input  logic            clk,
  input  logic            reset_n,
  fifo_stream_bh_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LG2;

  logic                       wr_acc;
  logic [FIFO_DEPTH_LG2-1:0]  wr_idx;
  logic [FIFO_DEPTH_LG2-1:0]  rd_idx;
  logic [DEPTH-1:0]           entry_we;
  logic [FIFO_DATA_WIDTH-1:0] mem_reg [DEPTH];

  fifo_stream_ctrl #(
    .FIFO_DEPTH_LG2 (FIFO_DEPTH_LG2),
    .AF_THRESH      (AF_THRESH),
    .AE_THRESH      (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .wren         (bus.wren_i),
    .rden         (bus.rden_i),
    .err_clr      (bus.err_clr_i),
    .wr_acc       (wr_acc),
    .wr_idx       (wr_idx),
    .rd_idx       (rd_idx),
    .full         (bus.full_o),
    .empty        (bus.empty_o),
    .almost_full  (bus.almost_full_o),
    .almost_empty (bus.almost_empty_o),
    .level        (bus.level_o),
    .overflow     (bus.overflow_o),
    .underflow    (bus.underflow_o)
  );

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_we
    assign entry_we[gi] = wr_acc && (wr_idx == FIFO_DEPTH_LG2'(gi));
  end

  // Entries are reset so an empty FIFO presents zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) mem_reg[i] <= bus.wdata_i;
      end
    end
  end

  assign bus.rdata_o = mem_reg[rd_idx];

endmodule
